// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
// Round-robin arbiter that lets NREQ write requesters share one FIFO write
// port. A winner holds the port for a burst that ends on req_last, or is
// force-released after MAX_BURST accepted beats. The block also derives a
// registered FIFO occupancy estimate from the local binary write pointer and
// the synchronized Gray read pointer.
//
// Ports
//   wclk, w_rstn      write-domain clock, asynchronous active-low reset
//   req_valid/last    per-requester beat valid and end-of-burst marker
//   req_data          packed per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         per-requester beat accept (only the owner, only when not full)
//   full              FIFO full; the only condition that blocks a write
//   b_wptr            binary write pointer (PTR_WIDTH+1 bits)
//   g_rptr_sync       Gray read pointer already synchronized into wclk
//   wen, wdata        FIFO write strobe and data
//   grant             one-hot current owner, zero when idle
//   wlevel            registered occupancy estimate
//   almost_full       registered, wlevel >= AF_LEVEL (advisory only)
//   burst_trunc       pulse on the beat that hits MAX_BURST without req_last
module wr_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int MAX_BURST  = 4,
  parameter int AF_LEVEL   = 6
) (
  input  logic                       wclk,
  input  logic                       w_rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       full,
  input  logic [PTR_WIDTH:0]         b_wptr,
  input  logic [PTR_WIDTH:0]         g_rptr_sync,
  output logic                       wen,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            grant,
  output logic [PTR_WIDTH:0]         wlevel,
  output logic                       almost_full,
  output logic                       burst_trunc
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  localparam logic [BCNT_W-1:0]    MAX_B    = BCNT_W'(MAX_BURST);
  localparam logic [PTR_WIDTH:0]   AF_L     = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W:0]       NREQ_E   = (IDX_W + 1)'(NREQ);
  localparam logic [NREQ-1:0]      ONE_HOT0 = {{(NREQ - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

  // First valid index at or after start, wrapping modulo NREQ. The sum is
  // one bit wider so non-power-of-two NREQ wraps correctly.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] win;
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      sum   = {1'b0, start} + (IDX_W + 1)'(off);
      sum   = (sum >= NREQ_E) ? (sum - NREQ_E) : sum;
      idx   = sum[IDX_W-1:0];
      win   = (!found && v[idx]) ? idx : win;
      found = found | v[idx];
    end
    return win;
  endfunction

  state_t             state_r, state_s;
  logic [NREQ-1:0]    grant_r, grant_s;
  logic [IDX_W-1:0]   gidx_r, gidx_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [BCNT_W-1:0]  beat_cnt_r, beat_cnt_s;
  logic [BCNT_W-1:0]  beat_inc_s;
  logic [IDX_W-1:0]   win_s;
  logic [PTR_WIDTH:0] level_s;
  logic [PTR_WIDTH:0] wlevel_r;
  logic               af_r;
  logic               accept_s;
  logic               last_s;
  logic               trunc_s;

  // Beat acceptance and burst-termination conditions for the current owner.
  always_comb begin
    accept_s   = (state_r == BURST) && req_valid[gidx_r] && !full;
    beat_inc_s = beat_cnt_r + BCNT_W'(1);
    last_s     = accept_s && req_last[gidx_r];
    trunc_s    = accept_s && !req_last[gidx_r] && (beat_inc_s == MAX_B);
    level_s    = b_wptr - gray2bin(g_rptr_sync);
  end

  // Next-state, grant and beat-counter logic.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    gidx_s     = gidx_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    win_s      = rr_pick(req_valid, rr_ptr_r);
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_s    = BURST;
          grant_s    = ONE_HOT0 << win_s;
          gidx_s     = win_s;
          rr_ptr_s   = (win_s == LAST_IDX) ? '0 : (win_s + IDX_W'(1));
          beat_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        // full or a gap in req_valid simply holds everything; no timeout
        if (last_s || trunc_s) begin
          state_s    = IDLE;
          grant_s    = '0;
          beat_cnt_s = '0;
        end else if (accept_s) begin
          beat_cnt_s = beat_inc_s;
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = '0;
        beat_cnt_s = '0;
      end
    endcase
  end

  // Arbitration state and level registers.
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      gidx_r     <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      wlevel_r   <= '0;
      af_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      gidx_r     <= gidx_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
      wlevel_r   <= level_s;
      af_r       <= (level_s >= AF_L);
    end
  end

  // Write-port outputs; ready, wen and trunc follow the owner combinationally.
  always_comb begin
    req_ready   = grant_r & {NREQ{accept_s}};
    wen         = accept_s;
    wdata       = req_data[int'(gidx_r) * DATA_WIDTH +: DATA_WIDTH];
    grant       = grant_r;
    wlevel      = wlevel_r;
    almost_full = af_r;
    burst_trunc = trunc_s;
  end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: reactive requester streams, a cycle-level
// reference model of owner / round-robin / beat count / level, a negedge
// compare process, and literal checks of grant order and beats per grant.
module tb_wr_port_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int PW   = 3;
  localparam int MB   = 4;
  localparam int AFL  = 6;

  logic              wclk = 1'b0;
  logic              w_rstn;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic              full, wen, almost_full, burst_trunc;
  logic [PW:0]       b_wptr, g_rptr_sync, wlevel;
  logic [DW-1:0]     wdata;

  wr_port_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .PTR_WIDTH(PW),
                    .MAX_BURST(MB), .AF_LEVEL(AFL)) dut (
    .wclk(wclk), .w_rstn(w_rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .full(full), .b_wptr(b_wptr),
    .g_rptr_sync(g_rptr_sync), .wen(wen), .wdata(wdata), .grant(grant),
    .wlevel(wlevel), .almost_full(almost_full), .burst_trunc(burst_trunc));

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // requester streams: beats left, burst length (0 = never last), position, sequence
  int rem[NREQ], blen[NREQ], pos[NREQ], seq[NREQ];
  logic [NREQ-1:0] acc_seen = '0;
  int stall_left = 0, stall_mode = 0, stall_done = 0;

  // observation logs
  int glog[$], gbeats[$];
  int trunc_cnt = 0, stall_cnt = 0;
  logic [NREQ-1:0] prev_grant = '0;

  // reference model
  int owner_m = -1, rr_m = 0, beats_m = 0;
  logic [PW:0] lvl_m = '0;
  logic af_m = 1'b0;

  function automatic logic [PW:0] g2b(input logic [PW:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic int rr_first(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [PW:0] level_of(input logic [PW:0] b, input logic [PW:0] g);
    logic [PW:0] d;
    d = b - g2b(g);
    return d;
  endfunction

  // reference model update
  always @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      owner_m <= -1; rr_m <= 0; beats_m <= 0; lvl_m <= '0; af_m <= 1'b0;
    end else begin
      lvl_m <= level_of(b_wptr, g_rptr_sync);
      af_m  <= (int'(level_of(b_wptr, g_rptr_sync)) >= AFL);
      if (owner_m < 0) begin
        if (req_valid != '0) begin
          owner_m <= rr_first(req_valid, rr_m);
          rr_m    <= (rr_first(req_valid, rr_m) + 1) % NREQ;
          beats_m <= 0;
        end
      end else if (req_valid[owner_m[1:0]] && !full) begin
        beats_m <= beats_m + 1;
        if (req_last[owner_m[1:0]] || (beats_m + 1 == MB)) owner_m <= -1;
      end
    end
  end

  // per-cycle comparison against the model, plus logging
  always @(negedge wclk) begin
    int e_grant;
    int e_acc;
    int o;
    o       = (owner_m < 0) ? 0 : owner_m;
    e_grant = (owner_m < 0) ? 0 : (1 << owner_m);
    e_acc   = (owner_m >= 0 && req_valid[o] && !full) ? 1 : 0;
    chk("grant", int'(grant), e_grant);
    chk("req_ready", int'(req_ready), e_acc ? e_grant : 0);
    chk("wen", int'(wen), e_acc);
    if (e_acc != 0) chk("wdata", int'(wdata), int'(req_data[o*DW +: DW]));
    chk("burst_trunc", int'(burst_trunc),
        (e_acc != 0 && !req_last[o] && beats_m + 1 == MB) ? 1 : 0);
    chk("wlevel", int'(wlevel), int'(lvl_m));
    chk("almost_full", int'(almost_full), int'(af_m));
    acc_seen = req_ready;
    if (grant != '0 && prev_grant == '0) begin
      glog.push_back(int'(grant));
      gbeats.push_back(0);
    end
    if (wen && gbeats.size() > 0) gbeats[gbeats.size()-1] = gbeats[gbeats.size()-1] + 1;
    if (burst_trunc) trunc_cnt++;
    if (full && grant != '0 && !wen) stall_cnt++;
    prev_grant = grant;
  end

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_last[i]  = (blen[i] != 0) && (pos[i] == blen[i] - 1);
      req_data[i*DW +: DW] = DW'(i * 64 + (seq[i] % 64));
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i]) begin
        rem[i]--;
        seq[i]++;
        pos[i] = ((blen[i] != 0) && (pos[i] == blen[i] - 1)) ? 0 : pos[i] + 1;
      end
    end
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) full = 1'b0;
    end else if (stall_mode != 0 && seq[1] == 1 && stall_done == 0) begin
      full = 1'b1;
      stall_left = 5;
      stall_done = 1;
    end
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    glog.delete(); gbeats.delete();
    trunc_cnt = 0; stall_cnt = 0; prev_grant = '0;
  endtask

  task automatic start_scenario();
    @(posedge wclk);
    #2;
    w_rstn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; blen[i] = 0; pos[i] = 0; seq[i] = 0;
    end
    full = 1'b0; stall_left = 0; stall_mode = 0; stall_done = 0;
    b_wptr = '0; g_rptr_sync = '0;
    apply();
    run(2);
    w_rstn = 1'b1;
    clear_logs();
  endtask

  initial begin
    w_rstn = 1'b0;
    full = 1'b0;
    b_wptr = 4'b1001;
    g_rptr_sync = 4'b0010;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1; blen[i] = 1; pos[i] = 0; seq[i] = 0;
    end
    apply();
    // reset state while every requester is valid and pointers are nonzero
    @(posedge wclk);
    #2;
    chk("rst_grant", int'(grant), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wen", int'(wen), 0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_trunc", int'(burst_trunc), 0);

    // all four valid, 2-beat bursts: order 0,1,2,3,0 with 2 beats each
    start_scenario();
    rem[0] = 4; rem[1] = 2; rem[2] = 2; rem[3] = 2;
    for (int i = 0; i < NREQ; i++) blen[i] = 2;
    apply();
    run(20);
    chk("rr_ngrants", glog.size(), 5);
    chk("rr_g0", glog[0], 1);
    chk("rr_g1", glog[1], 2);
    chk("rr_g2", glog[2], 4);
    chk("rr_g3", glog[3], 8);
    chk("rr_g4", glog[4], 1);
    for (int k = 0; k < 5; k++) chk("rr_beats", gbeats[k], 2);

    // requester 2 streams 10 beats with no last, requester 3 one single beat
    start_scenario();
    rem[2] = 10; blen[2] = 0;
    rem[3] = 1;  blen[3] = 1;
    apply();
    run(25);
    chk("tr_ngrants", glog.size(), 4);
    chk("tr_g0", glog[0], 4);
    chk("tr_g1", glog[1], 8);
    chk("tr_g2", glog[2], 4);
    chk("tr_g3", glog[3], 4);
    chk("tr_b0", gbeats[0], 4);
    chk("tr_b1", gbeats[1], 1);
    chk("tr_b2", gbeats[2], 4);
    chk("tr_b3", gbeats[3], 2);
    chk("tr_pulses", trunc_cnt, 2);

    // full for 5 cycles after beat 1 of a 4-beat burst ending exactly at MAX_BURST
    start_scenario();
    rem[1] = 4; blen[1] = 4; stall_mode = 1;
    apply();
    run(16);
    chk("st_ngrants", glog.size(), 1);
    chk("st_g0", glog[0], 2);
    chk("st_beats", gbeats[0], 4);
    chk("st_stall", stall_cnt, 5);
    chk("st_trunc", trunc_cnt, 0);

    // level from pointers, including the wrap case
    start_scenario();
    b_wptr = 4'b1001; g_rptr_sync = 4'b0010;
    chk("lv_before", int'(wlevel), 0);
    step();
    chk("lv_six", int'(wlevel), 6);
    chk("lv_af_hi", int'(almost_full), 1);
    b_wptr = 4'b0001; g_rptr_sync = 4'b1011;
    step();
    chk("lv_wrap", int'(wlevel), 4);
    chk("lv_af_lo", int'(almost_full), 0);
    b_wptr = 4'b1000; g_rptr_sync = 4'b0000;
    step();
    chk("lv_full", int'(wlevel), 8);
    chk("lv_af_full", int'(almost_full), 1);

    // reset during requester 1's burst
    start_scenario();
    rem[0] = 4; rem[1] = 2; rem[2] = 2; rem[3] = 2;
    for (int i = 0; i < NREQ; i++) blen[i] = 2;
    apply();
    run(5);
    chk("mr_owner", int'(grant), 2);
    w_rstn = 1'b0;
    #1;
    chk("mr_wen", int'(wen), 0);
    chk("mr_grant", int'(grant), 0);
    chk("mr_ready", int'(req_ready), 0);
    step();
    w_rstn = 1'b1;
    clear_logs();
    run(4);
    chk("mr_first", glog[0], 1);
    chk("mr_trunc", trunc_cnt, 0);

    // only requester 3, single-beat bursts
    start_scenario();
    rem[3] = 4; blen[3] = 1;
    apply();
    run(10);
    chk("sb_ngrants", glog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("sb_grant", glog[k], 8);
      chk("sb_beats", gbeats[k], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
